// File: rtl/nios_system_entity_dir_sched.sv
// Direction scheduler for one entity: arbitrates CPU and hardware requesters onto a
// 3-bit direction output, then holds the winner for a programmable number of frames.
module nios_system_entity_dir_sched #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned HOLD_W       = 8,
  parameter int unsigned DEFAULT_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_dir,
  output logic [NUM_REQ-1:0]     ack,
  input  logic                   frame_tick,
  input  logic [1:0]             address,
  input  logic                   chipselect,
  input  logic                   write_n,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  output logic [2:0]             out_port,
  output logic                   dir_strobe
);

  localparam int unsigned DIR_W = 3;
  localparam int unsigned LG_W  = 3;

  typedef enum logic {ST_IDLE, ST_HOLD} state_e;

  state_e              state_q, state_d;
  logic [DIR_W-1:0]    out_q, out_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                strobe_q, strobe_d;
  logic                cpu_pend_q, cpu_pend_d;
  logic [DIR_W-1:0]    cpu_dir_q, cpu_dir_d;
  logic [LG_W-1:0]     lg_q, lg_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [HOLD_W-1:0]   hold_reg_q, hold_reg_d;
  logic [NUM_REQ-1:0]  mask_q, mask_d;

  logic                wr_en_c;
  logic [NUM_REQ-1:0]  elig_c;
  logic                win_found_c;
  logic [LG_W-1:0]     win_idx_c;
  logic [DIR_W-1:0]    win_dir_c;
  logic [NUM_REQ-1:0]  win_ack_c;
  logic                unused_wd;

  assign wr_en_c   = chipselect & ~write_n;
  assign elig_c    = req & mask_q;
  assign unused_wd = ^writedata;

  // Round-robin search starting one past the last hardware grant
  always_comb begin
    int unsigned cand;
    win_found_c = 1'b0;
    win_idx_c   = '0;
    win_dir_c   = '0;
    win_ack_c   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(lg_q) + k + 32'd1;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found_c && ((elig_c >> cand) & NUM_REQ'(1)) != '0) begin
        win_found_c = 1'b1;
        win_idx_c   = LG_W'(cand);
        win_dir_c   = req_dir[3*cand +: 3];
        win_ack_c   = NUM_REQ'(1) << cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      out_q      <= '0;
      ack_q      <= '0;
      strobe_q   <= 1'b0;
      cpu_pend_q <= 1'b0;
      cpu_dir_q  <= '0;
      lg_q       <= LG_W'(NUM_REQ - 1);
      hold_cnt_q <= '0;
      hold_reg_q <= HOLD_W'(DEFAULT_HOLD);
      mask_q     <= '1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      ack_q      <= ack_d;
      strobe_q   <= strobe_d;
      cpu_pend_q <= cpu_pend_d;
      cpu_dir_q  <= cpu_dir_d;
      lg_q       <= lg_d;
      hold_cnt_q <= hold_cnt_d;
      hold_reg_q <= hold_reg_d;
      mask_q     <= mask_d;
    end
  end

  // Next-state and register updates
  always_comb begin
    logic load;
    state_d    = state_q;
    out_d      = out_q;
    ack_d      = '0;
    strobe_d   = 1'b0;
    cpu_pend_d = cpu_pend_q;
    cpu_dir_d  = cpu_dir_q;
    lg_d       = lg_q;
    hold_cnt_d = hold_cnt_q;
    hold_reg_d = hold_reg_q;
    mask_d     = mask_q;
    load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_pend_q) begin
          out_d      = cpu_dir_q;
          cpu_pend_d = 1'b0;
          load       = 1'b1;
        end else if (win_found_c) begin
          out_d = win_dir_c;
          ack_d = win_ack_c;
          lg_d  = win_idx_c;
          load  = 1'b1;
        end
        if (load) begin
          strobe_d   = 1'b1;
          hold_cnt_d = hold_reg_q;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (frame_tick) begin
          if (hold_cnt_q == '0) state_d = ST_IDLE;
          else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A DIR write overrides consumption of the previous pending value
    if (wr_en_c) begin
      case (address)
        2'd0: begin
          cpu_pend_d = 1'b1;
          cpu_dir_d  = writedata[DIR_W-1:0];
        end
        2'd1:    hold_reg_d = writedata[HOLD_W-1:0];
        2'd2:    mask_d     = writedata[NUM_REQ-1:0];
        default: ;
      endcase
    end
  end

  // Zero-latency register readback
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = 32'(out_q);
      2'd1:    readdata = 32'(hold_reg_q);
      2'd2:    readdata = 32'(mask_q);
      default: readdata = 32'({cpu_pend_q, lg_q, (state_q == ST_HOLD)});
    endcase
  end

  assign out_port   = out_q;
  assign ack        = ack_q;
  assign dir_strobe = strobe_q;

endmodule
